// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, instruction memory address width,
// and the state encoding of the instruction-memory loader FSM.
package cpu_pkg;

    localparam int INSTR_W     = 16;
    localparam int IMEM_ADDR_W = 9;

    // Loader FSM states, kept as plain constants so older tools and the
    // fetch-side code can share the encoding without enum casts.
    typedef logic [2:0] loader_state_t;

    localparam loader_state_t LD_IDLE    = 3'd0;
    localparam loader_state_t LD_LEN_HI  = 3'd1;
    localparam loader_state_t LD_LEN_LO  = 3'd2;
    localparam loader_state_t LD_DATA_HI = 3'd3;
    localparam loader_state_t LD_DATA_LO = 3'd4;
    localparam loader_state_t LD_WRITE   = 3'd5;
    localparam loader_state_t LD_DONE    = 3'd6;
    localparam loader_state_t LD_ERR     = 3'd7;

    // States in which the loader consumes a byte from the stream.
    function automatic logic loader_accepts_byte(input loader_state_t s);
        return (s == LD_LEN_HI) || (s == LD_LEN_LO) ||
               (s == LD_DATA_HI) || (s == LD_DATA_LO);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction memory loader. Accepts a big-endian byte stream (16-bit word
// count, then 16-bit instructions) and writes each instruction into the
// instruction BRAM, holding the CPU in reset until a load completes cleanly.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               imem_we,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    loader_state_t      state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;

    logic               hs;
    logic [15:0]        len_rx;
    logic [15:0]        idx_next;

    assign rx_ready = loader_accepts_byte(state_q);
    assign hs       = rx_valid & rx_ready;
    // Word count as it will be once the low length byte lands.
    assign len_rx   = {len_q[15:8], rx_data};
    assign idx_next = 16'(idx_q) + 16'd1;

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign imem_we    = we_q;
    assign cpu_hold   = hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

    // Next-state logic: stream parsing, word assembly and status flags.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_d = LD_LEN_HI;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            LD_LEN_HI: begin
                if (hs) begin
                    len_d[15:8] = rx_data;
                    state_d     = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (hs) begin
                    len_d[7:0] = rx_data;
                    if (len_rx == 16'd0) begin
                        state_d = LD_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if (32'(len_rx) > MAX_WORDS) begin
                        // Rejected before any write so the old program survives.
                        state_d = LD_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LD_DATA_HI;
                    end
                end
            end
            LD_DATA_HI: begin
                if (hs) begin
                    hi_d    = rx_data;
                    state_d = LD_DATA_LO;
                end
            end
            LD_DATA_LO: begin
                if (hs) begin
                    // Register the BRAM write so it appears during WRITE.
                    addr_d  = {idx_q[ADDR_W-2:0], 1'b0};
                    wdata_d = {hi_q, rx_data};
                    we_d    = 1'b1;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                idx_d = idx_q + 1'b1;
                if (idx_next == len_q) begin
                    state_d = LD_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = LD_DATA_HI;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader: drives length-prefixed byte
// streams and compares the BRAM writes against an array of expected words.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [8:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Write log seen by the BRAM (appended only by the monitor below).
    logic [8:0]  log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];

    logic [15:0] ref_words[256];

    imem_loader #(.ADDR_W(9), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Cycle counter and BRAM-port monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte (after an optional random gap) and wait for its handshake.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gaps;
        int cnt;
        gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        rx_valid = 1'b0;
        repeat (gaps) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        cnt = 0;
        while (!rx_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Start a load of n words taken from ref_words; optionally pulse start mid-load.
    task automatic run_load(input int n, input int maxgap, input bit mid_start);
        logic [15:0] nn;
        nn = 16'(n);
        pulse_start();
        send_byte(nn[15:8], maxgap);
        send_byte(nn[7:0], maxgap);
        for (int k = 0; k < n && k < 256; k++) begin
            if (mid_start && k == n / 2) pulse_start();
            send_byte(ref_words[k][15:8], maxgap);
            send_byte(ref_words[k][7:0], maxgap);
        end
    endtask

    // Reference: word k of the stream lands at byte address 2k, in order.
    task automatic check_writes(input string tag, input int first, input int n);
        int errs;
        int cnt;
        cnt = log_addr.size() - first;
        check({tag, "_we_count"}, 32'(cnt), 32'(n));
        errs = 0;
        for (int k = 0; k < n && k < cnt; k++) begin
            if (log_addr[first + k] !== 9'(2 * k)) errs++;
            if (log_data[first + k] !== ref_words[k]) errs++;
        end
        check({tag, "_bram_contents"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int first;
        int seen;
        int n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {23'd0, imem_addr}, 32'd0);
        check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted while the loader waits for a low data byte.
        first = log_addr.size();
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hA1, 0);
        check("datalo_ready", {31'd0, rx_ready}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_hold", {31'd0, cpu_hold}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, imem_we}, 32'd0);
        check("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("abort_no_write", 32'(log_addr.size() - first), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word load.
        ref_words[0] = 16'hA1B2;
        ref_words[1] = 16'hC3D4;
        first = log_addr.size();
        run_load(2, 0, 1'b0);
        wait_idle("basic");
        repeat (2) @(negedge clk);
        check_writes("basic", first, 2);
        if (log_cyc.size() >= first + 2)
            check("basic_word_spacing", 32'(log_cyc[first + 1] - log_cyc[first]), 32'd3);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_hold", {31'd0, cpu_hold}, 32'd0);
        check("basic_err", {31'd0, err}, 32'd0);
        check("basic_addr_hold", {23'd0, imem_addr}, 32'd2);

        // Zero-length load.
        first = log_addr.size();
        run_load(0, 0, 1'b0);
        wait_idle("zero");
        repeat (2) @(negedge clk);
        check("zero_we_count", 32'(log_addr.size() - first), 32'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_hold", {31'd0, cpu_hold}, 32'd0);

        // Oversize length is rejected without writes.
        first = log_addr.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        wait_idle("over");
        check("over_err", {31'd0, err}, 32'd1);
        check("over_done", {31'd0, done}, 32'd0);
        check("over_hold", {31'd0, cpu_hold}, 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_ready) seen++;
        end
        rx_valid = 1'b0;
        check("over_no_accept", 32'(seen), 32'd0);
        check("over_we_count", 32'(log_addr.size() - first), 32'd0);

        // Full capacity with random data.
        for (int k = 0; k < 256; k++) ref_words[k] = 16'($urandom);
        first = log_addr.size();
        run_load(256, 0, 1'b0);
        wait_idle("full");
        repeat (2) @(negedge clk);
        check_writes("full", first, 256);
        if (log_addr.size() > 0)
            check("full_last_addr", {23'd0, log_addr[log_addr.size() - 1]}, 32'h1FE);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_hold", {31'd0, cpu_hold}, 32'd0);

        // Random gaps and a start pulse in the middle of the load.
        n = int'($urandom_range(20, 60));
        for (int k = 0; k < n; k++) ref_words[k] = 16'($urandom);
        first = log_addr.size();
        run_load(n, 3, 1'b1);
        wait_idle("gaps");
        repeat (2) @(negedge clk);
        check_writes("gaps", first, n);
        check("gaps_done", {31'd0, done}, 32'd1);
        check("gaps_err", {31'd0, err}, 32'd0);

        // Same data without gaps must give the same writes.
        first = log_addr.size();
        run_load(n, 0, 1'b0);
        wait_idle("nogap");
        repeat (2) @(negedge clk);
        check_writes("nogap", first, n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
